frame_update_scheduler: RTL and testbench

Sequences one full raster sweep of the 16x12 frame tracker per game tick. It drives the tracker's scan enable and captures every cell the tracker flags as changed. Each changed cell is queued as a draw command (x, y, object code) for the downstream display draw engine. Queued commands drain over a valid/ready handshake, and the scan stalls instead of dropping commands when the queue fills.

---
 rtl/frame_update_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_frame_update_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_update_scheduler.sv
// -----------------------------------------------------------------------------
// frame_update_scheduler
//
// Runs one raster sweep of the frame tracker per game tick. Each cell the
// tracker reports as changed becomes a draw command (x, y, object code) in a
// small first-word-fall-through queue. The draw engine takes commands from the
// queue over a valid/ready handshake. When the queue is about to fill, the
// sweep pauses by holding trk_enable low, so no command is ever dropped.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   frame_start  game-tick pulse; if it arrives while busy, it is remembered
//   trk_x/y/obj  tracker's current cell and object code
//   trk_diff     tracker change flag; refers to the cell enabled one cycle ago
//   trk_enable   advances the tracker by one cell
//   draw_valid   a draw command is at the head of the queue
//   draw_ready   draw engine accepts the head command
//   draw_x/y/obj head draw command (zero while draw_valid is low)
//   busy         sweep or drain in progress
//   frame_done   one-cycle pulse when the sweep is finished and drained
//   diff_count   number of changed cells in the last completed sweep
//
// States
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for frame_start or a pending start
//   ST_SCAN  | enabling tracker cells, throttled by queue room
//   ST_FLUSH | sweep finished; waiting for capture stage and queue to empty
//   ST_DONE  | one cycle: pulse frame_done, publish diff_count
// -----------------------------------------------------------------------------
module frame_update_scheduler #(
    parameter int COLS       = 16,
    parameter int ROWS       = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic [3:0] trk_x,
    input  logic [3:0] trk_y,
    input  logic [2:0] trk_obj,
    input  logic       trk_diff,
    output logic       trk_enable,
    output logic       draw_valid,
    input  logic       draw_ready,
    output logic [3:0] draw_x,
    output logic [3:0] draw_y,
    output logic [2:0] draw_obj,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] diff_count
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [7:0]    LAST_CELL = 8'(COLS * ROWS - 1);
    localparam logic [AW+1:0] DEPTH_LIM = (AW + 2)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          start_pend_q, start_pend_d;
    logic [7:0]    diff_run_q, diff_run_d;
    logic [7:0]    diff_count_q, diff_count_d;

    logic          stage_valid_q, stage_valid_d;
    logic [EW-1:0] stage_q, stage_d;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic          scan_en;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [AW+1:0] occ_sum;
    logic [EW-1:0] head;

    // ------------------------------------------------------------------
    // Queue status
    // ------------------------------------------------------------------
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign push       = stage_valid_q & trk_diff;
    assign pop        = ~fifo_empty & draw_ready;

    // The stage is counted as if it were already in the queue. This reserves
    // a slot for it, so the push that comes one cycle after an enable always
    // has room.
    assign occ_sum = {1'b0, count_q} + {{(AW + 1){1'b0}}, stage_valid_q};

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        start_pend_d = start_pend_q;
        diff_run_d   = diff_run_q;
        diff_count_d = diff_count_q;
        scan_en      = 1'b0;

        if (push && (diff_run_q != 8'hFF)) begin
            diff_run_d = diff_run_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start || start_pend_q) begin
                    state_d    = ST_SCAN;
                    cnt_d      = '0;
                    diff_run_d = '0;
                end
            end
            ST_SCAN: begin
                scan_en = (occ_sum < DEPTH_LIM);
                if (scan_en) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST_CELL) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (!stage_valid_q && fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                diff_count_d = diff_run_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // In IDLE, any request is consumed by the transition to SCAN. In every
        // other state, ticks are collapsed into a single pending start.
        if (state_q == ST_IDLE) begin
            start_pend_d = 1'b0;
        end else if (frame_start) begin
            start_pend_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Capture stage: holds the enabled cell until trk_diff for it arrives
    // ------------------------------------------------------------------
    always_comb begin
        stage_valid_d = scan_en;
        stage_d       = stage_q;
        if (scan_en) begin
            stage_d = {trk_x, trk_y, trk_obj};
        end
    end

    // ------------------------------------------------------------------
    // Draw-command queue
    // ------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = stage_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            start_pend_q  <= 1'b0;
            diff_run_q    <= '0;
            diff_count_q  <= '0;
            stage_valid_q <= 1'b0;
            stage_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            start_pend_q  <= start_pend_d;
            diff_run_q    <= diff_run_d;
            diff_count_q  <= diff_count_d;
            stage_valid_q <= stage_valid_d;
            stage_q       <= stage_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mem_q         <= mem_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign trk_enable = scan_en;
    assign draw_valid = ~fifo_empty;
    assign draw_x     = fifo_empty ? 4'd0 : head[10:7];
    assign draw_y     = fifo_empty ? 4'd0 : head[6:3];
    assign draw_obj   = fifo_empty ? 3'd0 : head[2:0];
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign diff_count = diff_count_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for frame_update_scheduler. A tracker model walks cells 0..191 in
// raster order and advances only when trk_enable is high. For each sweep, the
// expected command list is the ordered list of flagged cells.
// -----------------------------------------------------------------------------
module tb_frame_update_scheduler;

    localparam int NCELL = 192;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic [3:0] trk_x;
    logic [3:0] trk_y;
    logic [2:0] trk_obj;
    logic       trk_diff;
    logic       trk_enable;
    logic       draw_valid;
    logic       draw_ready;
    logic [3:0] draw_x;
    logic [3:0] draw_y;
    logic [2:0] draw_obj;
    logic       busy;
    logic       frame_done;
    logic [7:0] diff_count;

    int checks = 0;
    int errors = 0;

    bit         diff_map [NCELL];
    logic [2:0] obj_map  [NCELL];
    int         p = 0;
    bit         en_prev = 1'b0;

    int          cyc = 0;
    int          en_count = 0;
    int          valid_cycles = 0;
    int          done_count = 0;
    logic [10:0] obs_q [$];
    logic [10:0] exp_q [$];
    int          done_cyc_q [$];
    int          start_cyc_q [$];
    logic        busy_prev = 1'b0;

    always #5 clk = ~clk;

    frame_update_scheduler #(.COLS(16), .ROWS(12), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .trk_x(trk_x), .trk_y(trk_y), .trk_obj(trk_obj), .trk_diff(trk_diff),
        .trk_enable(trk_enable), .draw_valid(draw_valid), .draw_ready(draw_ready),
        .draw_x(draw_x), .draw_y(draw_y), .draw_obj(draw_obj),
        .busy(busy), .frame_done(frame_done), .diff_count(diff_count)
    );

    // Tracker model. An enable sampled at a posedge consumes the presented
    // cell. Its diff flag appears in the next cycle, and the next cell is
    // presented.
    initial begin
        trk_x = '0; trk_y = '0; trk_obj = '0; trk_diff = 1'b0;
        forever begin
            @(negedge clk);
            if (en_prev) begin
                trk_diff = diff_map[p];
                p = (p + 1) % NCELL;
            end else begin
                trk_diff = 1'($urandom);
            end
            trk_x   = 4'(p % 16);
            trk_y   = 4'(p / 16);
            trk_obj = obj_map[p];
            en_prev = (trk_enable === 1'b1);
        end
    end

    // Observer: samples between edges, after all inputs have settled.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (trk_enable === 1'b1) en_count++;
            if (draw_valid === 1'b1) valid_cycles++;
            if (draw_valid === 1'b1 && draw_ready === 1'b1)
                obs_q.push_back({draw_x, draw_y, draw_obj});
            if (frame_done === 1'b1) begin
                done_count++;
                done_cyc_q.push_back(cyc);
            end
            if (busy === 1'b1 && busy_prev !== 1'b1) start_cyc_q.push_back(cyc);
            busy_prev = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        en_count = 0; valid_cycles = 0; done_count = 0;
        obs_q.delete(); done_cyc_q.delete(); start_cyc_q.delete();
    endtask

    // mode 0: no cell flagged, 1: all flagged, 2: about one third flagged
    task automatic set_maps(input int mode);
        for (int i = 0; i < NCELL; i++) begin
            obj_map[i]  = 3'($urandom_range(0, 4));
            diff_map[i] = (mode == 1) ? 1'b1 :
                          (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
    endtask

    task automatic build_exp();
        exp_q.delete();
        for (int k = 0; k < NCELL; k++) begin
            int idx;
            idx = (p + k) % NCELL;
            if (diff_map[idx]) exp_q.push_back({4'(idx % 16), 4'(idx / 16), obj_map[idx]});
        end
    endtask

    task automatic start_sweep();
        @(negedge clk);
        p = 0;
        clear_mon();
        build_exp();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input bit rnd_ready,
                             output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rnd_ready) draw_ready = 1'($urandom_range(0, 1));
            if (done_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
        draw_ready = 1'b1;
        #3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        checks++; if (trk_enable !== 1'b0) begin errors++; $display("FAIL reset_trk_enable got %b want 0", trk_enable); end
        checks++; if (draw_valid !== 1'b0) begin errors++; $display("FAIL reset_draw_valid got %b want 0", draw_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        checks++; if (diff_count !== 8'd0) begin errors++; $display("FAIL reset_diff_count got %0d want 0", diff_count); end
        checks++; if ({draw_x, draw_y, draw_obj} !== 11'd0) begin errors++; $display("FAIL reset_draw_cmd got %h want 0", {draw_x, draw_y, draw_obj}); end
    endtask

    task automatic test_no_diff();
        bit ok;
        set_maps(0);
        draw_ready = 1'b1;
        start_sweep();
        wait_done(1, 1000, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nodiff_done got timeout want frame_done"); end
        checks++; if (en_count !== NCELL) begin errors++; $display("FAIL nodiff_enables got %0d want %0d", en_count, NCELL); end
        checks++; if (valid_cycles !== 0) begin errors++; $display("FAIL nodiff_valid_cycles got %0d want 0", valid_cycles); end
        checks++; if (diff_count !== 8'd0) begin errors++; $display("FAIL nodiff_diff_count got %0d want 0", diff_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nodiff_busy got %b want 0", busy); end
        repeat (5) @(negedge clk);
        checks++; if (done_count !== 1) begin errors++; $display("FAIL nodiff_done_pulses got %0d want 1", done_count); end
    endtask

    task automatic test_three_diffs();
        bit ok;
        int n;
        set_maps(0);
        diff_map[0] = 1'b1; diff_map[15] = 1'b1; diff_map[7 * 16 + 5] = 1'b1;
        start_sweep();
        wait_done(1, 2000, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL three_done got timeout want frame_done"); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL three_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL three_cmd[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (diff_count !== 8'd3) begin errors++; $display("FAIL three_diff_count got %0d want 3", diff_count); end
        checks++; if (en_count !== NCELL) begin errors++; $display("FAIL three_enables got %0d want %0d", en_count, NCELL); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        logic [10:0] h;
        set_maps(1);
        draw_ready = 1'b0;
        start_sweep();
        repeat (30) @(negedge clk);
        #3;
        checks++; if (en_count !== DEPTH) begin errors++; $display("FAIL bp_stall_enables got %0d want %0d", en_count, DEPTH); end
        checks++; if (trk_enable !== 1'b0) begin errors++; $display("FAIL bp_stall_trk_enable got %b want 0", trk_enable); end
        checks++; if (draw_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid got %b want 1", draw_valid); end
        h = {draw_x, draw_y, draw_obj};
        checks++; if (h !== exp_q[0]) begin errors++; $display("FAIL bp_head got %h want %h", h, exp_q[0]); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #3;
            checks++; if ({draw_x, draw_y, draw_obj} !== h || draw_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d] got %h/%b want %h/1", i, {draw_x, draw_y, draw_obj}, draw_valid, h);
            end
        end
        wait_done(1, 3000, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_done got timeout want frame_done"); end
        checks++; if (en_count !== NCELL) begin errors++; $display("FAIL bp_enables got %0d want %0d", en_count, NCELL); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_cmd[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (diff_count !== 8'(NCELL)) begin errors++; $display("FAIL bp_diff_count got %0d want %0d", diff_count, NCELL); end
    endtask

    task automatic test_pending_start();
        bit ok;
        set_maps(0);
        draw_ready = 1'b1;
        start_sweep();
        for (int k = 0; k < 3; k++) begin
            repeat (30) @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
        wait_done(2, 1500, 1'b0, ok);
        repeat (60) @(negedge clk);
        #3;
        checks++; if (!ok) begin errors++; $display("FAIL pend_done got timeout want two frame_done"); end
        checks++; if (done_count !== 2) begin errors++; $display("FAIL pend_done_pulses got %0d want 2", done_count); end
        checks++; if (en_count !== 2 * NCELL) begin errors++; $display("FAIL pend_enables got %0d want %0d", en_count, 2 * NCELL); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pend_busy got %b want 0", busy); end
        checks++; if (start_cyc_q.size() !== 2) begin errors++; $display("FAIL pend_sweeps got %0d want 2", start_cyc_q.size()); end
        if (start_cyc_q.size() >= 2 && done_cyc_q.size() >= 1) begin
            checks++; if (start_cyc_q[1] !== done_cyc_q[0] + 2) begin
                errors++; $display("FAIL pend_restart_cycle got %0d want %0d", start_cyc_q[1], done_cyc_q[0] + 2);
            end
        end
    endtask

    task automatic test_random_frames();
        bit ok;
        int n;
        int exp_dc;
        for (int f = 0; f < 3; f++) begin
            set_maps(2);
            start_sweep();
            wait_done(1, 3000, 1'b1, ok);
            exp_dc = (exp_q.size() > 255) ? 255 : exp_q.size();
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d_done got timeout want frame_done", f); end
            checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", f, obs_q.size(), exp_q.size()); end
            n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
            for (int i = 0; i < n; i++) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_cmd[%0d] got %h want %h", f, i, obs_q[i], exp_q[i]); end
            end
            checks++; if (diff_count !== 8'(exp_dc)) begin errors++; $display("FAIL rand%0d_diff_count got %0d want %0d", f, diff_count, exp_dc); end
            checks++; if (en_count !== NCELL) begin errors++; $display("FAIL rand%0d_enables got %0d want %0d", f, en_count, NCELL); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit ok;
        bit reached;
        int n;
        int exp_dc;
        logic [7:0] prev_dc;
        prev_dc = diff_count;
        set_maps(0);
        diff_map[96] = 1'b1; diff_map[97] = 1'b1;
        draw_ready = 1'b0;
        start_sweep();
        reached = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (en_count >= 100) begin
                reached = 1'b1;
                break;
            end
        end
        #3;
        checks++; if (!reached) begin errors++; $display("FAIL rstmid_reach got %0d enables want 100", en_count); end
        checks++; if (draw_valid !== 1'b1) begin errors++; $display("FAIL rstmid_queued got %b want 1", draw_valid); end
        checks++; if (diff_count !== prev_dc) begin errors++; $display("FAIL rstmid_hold_dc got %0d want %0d", diff_count, prev_dc); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        checks++; if (draw_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", draw_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (trk_enable !== 1'b0) begin errors++; $display("FAIL rstmid_trk_enable got %b want 0", trk_enable); end
        checks++; if (diff_count !== 8'd0) begin errors++; $display("FAIL rstmid_diff_count got %0d want 0", diff_count); end
        draw_ready = 1'b1;
        set_maps(2);
        start_sweep();
        wait_done(1, 3000, 1'b1, ok);
        exp_dc = (exp_q.size() > 255) ? 255 : exp_q.size();
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_done got timeout want frame_done"); end
        checks++; if (en_count !== NCELL) begin errors++; $display("FAIL rstmid_enables got %0d want %0d", en_count, NCELL); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_cmd[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (diff_count !== 8'(exp_dc)) begin errors++; $display("FAIL rstmid_final_dc got %0d want %0d", diff_count, exp_dc); end
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        draw_ready = 1'b0;
        for (int i = 0; i < NCELL; i++) begin
            diff_map[i] = 1'b0;
            obj_map[i]  = 3'd0;
        end
        test_reset();
        test_no_diff();
        test_three_diffs();
        test_backpressure();
        test_pending_start();
        test_random_frames();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
